// File: rtl/lab3_cache_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lab3_cache_cache_arbiter
// Brief    : Two-port request arbiter and flush sequencer in front of a
//            single blocking cache (port 0 = ifetch, port 1 = data).
// Revision : 1.0 - initial release
// ============================================================================
module lab3_cache_cache_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_memreq_val,
    output logic        p0_memreq_rdy,
    input  logic [76:0] p0_memreq_msg,
    output logic        p0_memresp_val,
    input  logic        p0_memresp_rdy,
    output logic [46:0] p0_memresp_msg,

    input  logic        p1_memreq_val,
    output logic        p1_memreq_rdy,
    input  logic [76:0] p1_memreq_msg,
    output logic        p1_memresp_val,
    input  logic        p1_memresp_rdy,
    output logic [46:0] p1_memresp_msg,

    output logic        cache_req_val,
    input  logic        cache_req_rdy,
    output logic [76:0] cache_req_msg,
    input  logic        cache_resp_val,
    output logic        cache_resp_rdy,
    input  logic [46:0] cache_resp_msg,

    input  logic        flush,
    output logic        flush_done,
    output logic        cache_flush,
    input  logic        cache_flush_done
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SEND  = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_RESP  = 3'd3;
    localparam logic [2:0] c_FLUSH = 3'd4;
    localparam logic [2:0] c_FDONE = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [76:0] r_req_buf;
    logic [46:0] r_resp_buf;
    logic        r_owner;
    logic        r_last_grant;
    logic        w_win;
    logic        w_accept;

    // w_win is the port that would be granted if anything is valid
    generate
        if (PRIO_MODE == 1) begin : g_fixed_prio
            assign w_win = ~p0_memreq_val;
        end else begin : g_round_robin
            logic w_pref_val;
            assign w_pref_val = r_last_grant ? p0_memreq_val : p1_memreq_val;
            assign w_win      = w_pref_val ? ~r_last_grant : r_last_grant;
        end
    endgenerate

    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        p0_memreq_rdy  = 1'b0;
        p1_memreq_rdy  = 1'b0;
        p0_memresp_val = 1'b0;
        p1_memresp_val = 1'b0;
        cache_req_val  = 1'b0;
        cache_resp_rdy = 1'b0;
        cache_flush    = 1'b0;
        flush_done     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (flush) begin
                    w_state_nxt = c_FLUSH;
                end else if (p0_memreq_val || p1_memreq_val) begin
                    w_accept      = 1'b1;
                    // rdy is combinational, so hold it low while reset is asserted
                    p0_memreq_rdy = reset & ~w_win;
                    p1_memreq_rdy = reset & w_win;
                    w_state_nxt   = c_SEND;
                end
            end
            c_SEND: begin
                cache_req_val = 1'b1;
                if (cache_req_rdy) w_state_nxt = c_WAIT;
            end
            c_WAIT: begin
                cache_resp_rdy = 1'b1;
                if (cache_resp_val) w_state_nxt = c_RESP;
            end
            c_RESP: begin
                p0_memresp_val = ~r_owner;
                p1_memresp_val = r_owner;
                if (r_owner ? p1_memresp_rdy : p0_memresp_rdy) w_state_nxt = c_IDLE;
            end
            c_FLUSH: begin
                cache_flush = 1'b1;
                if (cache_flush_done) w_state_nxt = c_FDONE;
            end
            c_FDONE: begin
                flush_done  = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    assign cache_req_msg  = cache_req_val  ? r_req_buf  : '0;
    assign p0_memresp_msg = p0_memresp_val ? r_resp_buf : '0;
    assign p1_memresp_msg = p1_memresp_val ? r_resp_buf : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_IDLE;
            r_req_buf    <= '0;
            r_resp_buf   <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_req_buf    <= w_win ? p1_memreq_msg : p0_memreq_msg;
                r_owner      <= w_win;
                r_last_grant <= w_win;
            end
            if (r_state == c_WAIT && cache_resp_val) begin
                r_resp_buf <= cache_resp_msg;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lab3_cache_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab3_cache_cache_arbiter
// Brief    : Self-checking bench; instance 0 round-robin, instance 1 fixed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lab3_cache_cache_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_val  [2];
    logic [76:0] req_msg  [2][2];
    logic [1:0]  resp_rdy [2];
    logic        rdy0 [2], rdy1 [2], rv0 [2], rv1 [2];
    logic [46:0] rm0 [2], rm1 [2];
    logic        cache_req_val [2], cache_req_rdy [2];
    logic        cache_resp_val [2], cache_resp_rdy [2];
    logic [76:0] cache_req_msg [2];
    logic [46:0] cache_resp_msg [2];
    logic        flush [2], flush_done [2], cache_flush [2], cache_flush_done [2];

    int tests_run = 0;
    int fails     = 0;
    int model_last [2];
    int grants [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lab3_cache_cache_arbiter #(.PRIO_MODE(g)) u_dut (
            .clk              (clk),
            .reset            (reset),
            .p0_memreq_val    (req_val[g][0]),
            .p0_memreq_rdy    (rdy0[g]),
            .p0_memreq_msg    (req_msg[g][0]),
            .p0_memresp_val   (rv0[g]),
            .p0_memresp_rdy   (resp_rdy[g][0]),
            .p0_memresp_msg   (rm0[g]),
            .p1_memreq_val    (req_val[g][1]),
            .p1_memreq_rdy    (rdy1[g]),
            .p1_memreq_msg    (req_msg[g][1]),
            .p1_memresp_val   (rv1[g]),
            .p1_memresp_rdy   (resp_rdy[g][1]),
            .p1_memresp_msg   (rm1[g]),
            .cache_req_val    (cache_req_val[g]),
            .cache_req_rdy    (cache_req_rdy[g]),
            .cache_req_msg    (cache_req_msg[g]),
            .cache_resp_val   (cache_resp_val[g]),
            .cache_resp_rdy   (cache_resp_rdy[g]),
            .cache_resp_msg   (cache_resp_msg[g]),
            .flush            (flush[g]),
            .flush_done       (flush_done[g]),
            .cache_flush      (cache_flush[g]),
            .cache_flush_done (cache_flush_done[g])
        );
    end

    function automatic logic [76:0] rand_req();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[76:0];
    endfunction

    function automatic logic [46:0] rand_resp();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[46:0];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            req_val[d] = 2'b00; resp_rdy[d] = 2'b00;
            req_msg[d][0] = '0; req_msg[d][1] = '0;
            cache_req_rdy[d] = 1'b0; cache_resp_val[d] = 1'b0; cache_resp_msg[d] = '0;
            flush[d] = 1'b0; cache_flush_done[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        clear_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        req_val[0] = 2'b11; req_val[1] = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            obs = {rdy1[d], rdy0[d], rv1[d], rv0[d], cache_req_val[d], cache_resp_rdy[d],
                   cache_flush[d], flush_done[d], |cache_req_msg[d], |(rm0[d] | rm1[d])};
            tests_run++;
            if (obs !== 10'd0) begin
                fails++;
                $display("FAIL reset_outputs d%0d: got %b want 0000000000", d, obs);
            end
        end
        @(negedge clk);
        req_val[0] = 2'b00; req_val[1] = 2'b00;
        reset = 1'b1;
        model_last[0] = 1; model_last[1] = 1;
        @(negedge clk);
    endtask

    // Runs n0 requests on port 0 and n1 on port 1 through instance d; negative delays are randomised.
    task automatic test_txn_stream(input int d, input int n0, input int n1,
                                   input int rq, input int rs, input int od, input string name);
        int cnt [2];
        int w, dq, ds, dout;
        logic [1:0]  wm, grant_obs;
        logic [76:0] exp_req;
        logic [46:0] exp_resp, got_resp;
        cnt[0] = n0; cnt[1] = n1;
        req_msg[d][0] = rand_req(); req_msg[d][1] = rand_req();
        while (cnt[0] + cnt[1] > 0) begin
            req_val[d] = {cnt[1] > 0, cnt[0] > 0};
            if (d == 0 && req_val[d] == 2'b11) w = 1 - model_last[d];
            else w = req_val[d][0] ? 0 : 1;
            wm = (w == 0) ? 2'b01 : 2'b10;
            exp_req = req_msg[d][w];
            #1;
            grant_obs = {rdy1[d], rdy0[d]};
            tests_run++;
            if (grant_obs !== wm) begin
                fails++;
                $display("FAIL %s_grant d%0d: got %b want %b", name, d, grant_obs, wm);
            end
            grants.push_back(grant_obs == 2'b10 ? 1 : (grant_obs == 2'b01 ? 0 : -1));
            step();
            model_last[d] = w;
            cnt[w]--;
            req_msg[d][w] = rand_req();
            req_val[d] = {cnt[1] > 0, cnt[0] > 0};
            dq   = (rq < 0) ? int'($urandom_range(3)) : rq;
            ds   = (rs < 0) ? int'($urandom_range(3)) : rs;
            dout = (od < 0) ? int'($urandom_range(3)) : od;
            for (int k = 0; k <= dq; k++) begin
                cache_req_rdy[d] = (k == dq);
                #1;
                tests_run++;
                if ({cache_req_val[d], cache_req_msg[d], rdy1[d], rdy0[d]} !== {1'b1, exp_req, 2'b00}) begin
                    fails++;
                    $display("FAIL %s_send d%0d k%0d: got %b/%h want 1/%h", name, d, k,
                             cache_req_val[d], cache_req_msg[d], exp_req);
                end
                step();
            end
            cache_req_rdy[d] = 1'b0;
            exp_resp = rand_resp();
            for (int k = 0; k <= ds; k++) begin
                cache_resp_val[d] = (k == ds);
                cache_resp_msg[d] = (k == ds) ? exp_resp : rand_resp();
                #1;
                tests_run++;
                if ({cache_resp_rdy[d], cache_req_val[d], rdy1[d], rdy0[d], rv1[d], rv0[d]} !== 6'b100000) begin
                    fails++;
                    $display("FAIL %s_wait d%0d k%0d: got %b want 100000", name, d, k,
                             {cache_resp_rdy[d], cache_req_val[d], rdy1[d], rdy0[d], rv1[d], rv0[d]});
                end
                step();
            end
            cache_resp_val[d] = 1'b0;
            cache_resp_msg[d] = rand_resp();
            for (int k = 0; k <= dout; k++) begin
                resp_rdy[d] = (k == dout) ? 2'b11 : ~wm;
                #1;
                got_resp = (w == 0) ? rm0[d] : rm1[d];
                tests_run++;
                if ({rv1[d], rv0[d], got_resp, rdy1[d], rdy0[d]} !== {wm, exp_resp, 2'b00}) begin
                    fails++;
                    $display("FAIL %s_resp d%0d k%0d: got %b/%h want %b/%h", name, d, k,
                             {rv1[d], rv0[d]}, got_resp, wm, exp_resp);
                end
                step();
            end
            resp_rdy[d] = 2'b00;
        end
        req_val[d] = 2'b00;
        #1;
        tests_run++;
        if ({rv1[d], rv0[d], cache_req_val[d]} !== 3'b000) begin
            fails++;
            $display("FAIL %s_idle d%0d: got %b want 000", name, d, {rv1[d], rv0[d], cache_req_val[d]});
        end
        @(negedge clk);
    endtask

    task automatic check_order(input string name, input int exp_q [$]);
        tests_run++;
        if (grants != exp_q) begin
            fails++;
            $display("FAIL %s_order: got %p want %p", name, grants, exp_q);
        end
    endtask

    task automatic test_round_robin();
        grants.delete();
        test_txn_stream(0, 3, 3, -1, -1, -1, "rr");
        check_order("rr", '{0, 1, 0, 1, 0, 1});
    endtask

    task automatic test_fixed_prio();
        grants.delete();
        test_txn_stream(1, 4, 4, -1, -1, -1, "fixed");
        check_order("fixed", '{0, 0, 0, 0, 1, 1, 1, 1});
    endtask

    task automatic test_single_read();
        logic [76:0] req;
        logic [46:0] rsp, got;
        req = {3'd0, 8'h5A, 32'h0000_1000, 2'd0, 32'd0};
        rsp = {3'd0, 8'h5A, 2'd0, 2'd0, 32'hDEAD_BEEF};
        req_val[0] = 2'b01; req_msg[0][0] = req;
        cache_req_rdy[0] = 1'b1;
        #1;
        tests_run++;
        if ({rdy1[0], rdy0[0]} !== 2'b01) begin
            fails++; $display("FAIL single_grant: got %b want 01", {rdy1[0], rdy0[0]});
        end
        step();
        req_val[0] = 2'b00; model_last[0] = 0;
        #1;
        tests_run++;
        if ({cache_req_val[0], cache_req_msg[0]} !== {1'b1, req}) begin
            fails++; $display("FAIL single_req: got %b/%h want 1/%h", cache_req_val[0], cache_req_msg[0], req);
        end
        step();
        cache_req_rdy[0] = 1'b0;
        cache_resp_val[0] = 1'b1; cache_resp_msg[0] = rsp;
        step();
        cache_resp_val[0] = 1'b0; cache_resp_msg[0] = '0;
        #1;
        got = rm0[0];
        tests_run++;
        if ({rv1[0], rv0[0], got[43:36], got[31:0]} !== {2'b01, 8'h5A, 32'hDEAD_BEEF}) begin
            fails++; $display("FAIL single_resp: got %b/%h want 01/%h", {rv1[0], rv0[0]}, got, rsp);
        end
        resp_rdy[0] = 2'b01;
        step();
        resp_rdy[0] = 2'b00;
        #1;
        tests_run++;
        if ({rv1[0], rv0[0]} !== 2'b00) begin
            fails++; $display("FAIL single_done: got %b want 00", {rv1[0], rv0[0]});
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        req_val[0] = 2'b01; req_msg[0][0] = rand_req();
        #1;
        tests_run++;
        if ({rdy1[0], rdy0[0]} !== 2'b01) begin
            fails++; $display("FAIL flush_grant: got %b want 01", {rdy1[0], rdy0[0]});
        end
        step();
        req_val[0] = 2'b00; model_last[0] = 0;
        cache_req_rdy[0] = 1'b1;
        step();
        cache_req_rdy[0] = 1'b0;
        flush[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cache_resp_val[0] = (k == 2);
            #1;
            tests_run++;
            if ({cache_flush[0], cache_resp_rdy[0]} !== 2'b01) begin
                fails++; $display("FAIL flush_wait k%0d: got %b want 01", k, {cache_flush[0], cache_resp_rdy[0]});
            end
            step();
        end
        cache_resp_val[0] = 1'b0;
        req_val[0] = 2'b10;
        for (int k = 0; k < 2; k++) begin
            resp_rdy[0] = (k == 1) ? 2'b01 : 2'b00;
            #1;
            tests_run++;
            if ({cache_flush[0], rv1[0], rv0[0], rdy1[0], rdy0[0]} !== 5'b00100) begin
                fails++; $display("FAIL flush_resp k%0d: got %b want 00100", k,
                                  {cache_flush[0], rv1[0], rv0[0], rdy1[0], rdy0[0]});
            end
            step();
        end
        resp_rdy[0] = 2'b00;
        #1;
        tests_run++;
        if ({cache_flush[0], rdy1[0], rdy0[0]} !== 3'b000) begin
            fails++; $display("FAIL flush_idle: got %b want 000", {cache_flush[0], rdy1[0], rdy0[0]});
        end
        step();
        for (int k = 0; k <= 10; k++) begin
            cache_flush_done[0] = (k == 10);
            #1;
            tests_run++;
            if ({cache_flush[0], flush_done[0], rdy1[0], rdy0[0]} !== 4'b1000) begin
                fails++; $display("FAIL flush_active k%0d: got %b want 1000", k,
                                  {cache_flush[0], flush_done[0], rdy1[0], rdy0[0]});
            end
            step();
        end
        cache_flush_done[0] = 1'b0;
        #1;
        tests_run++;
        if ({flush_done[0], cache_flush[0], rdy1[0], rdy0[0]} !== 4'b1000) begin
            fails++; $display("FAIL flush_done_pulse: got %b want 1000",
                              {flush_done[0], cache_flush[0], rdy1[0], rdy0[0]});
        end
        flush[0] = 1'b0; req_val[0] = 2'b00;
        step();
        #1;
        tests_run++;
        if ({flush_done[0], cache_flush[0]} !== 2'b00) begin
            fails++; $display("FAIL flush_done_width: got %b want 00", {flush_done[0], cache_flush[0]});
        end
        @(negedge clk);
    endtask

    task automatic test_spurious_resp();
        cache_resp_val[0] = 1'b1; cache_resp_msg[0] = rand_resp();
        #1;
        tests_run++;
        if ({cache_resp_rdy[0], cache_req_val[0]} !== 2'b00) begin
            fails++; $display("FAIL spurious_idle: got %b want 00", {cache_resp_rdy[0], cache_req_val[0]});
        end
        step();
        cache_resp_val[0] = 1'b0;
        #1;
        tests_run++;
        if ({rv1[0], rv0[0], cache_resp_rdy[0], cache_req_val[0]} !== 4'b0000) begin
            fails++; $display("FAIL spurious_after: got %b want 0000",
                              {rv1[0], rv0[0], cache_resp_rdy[0], cache_req_val[0]});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        req_val[0] = 2'b01; req_msg[0][0] = rand_req();
        cache_req_rdy[0] = 1'b1;
        step();
        req_val[0] = 2'b11;
        step();
        cache_req_rdy[0] = 1'b0;
        #1;
        tests_run++;
        if (cache_resp_rdy[0] !== 1'b1) begin
            fails++; $display("FAIL midrst_inwait: got %b want 1", cache_resp_rdy[0]);
        end
        #1 reset = 1'b0;
        #1;
        tests_run++;
        if ({rdy1[0], rdy0[0], rv1[0], rv0[0], cache_req_val[0], cache_resp_rdy[0],
             cache_flush[0], flush_done[0], |cache_req_msg[0], |(rm0[0] | rm1[0])} !== 10'd0) begin
            fails++; $display("FAIL midrst_outputs: got %b want 0000000000",
                              {rdy1[0], rdy0[0], rv1[0], rv0[0], cache_req_val[0], cache_resp_rdy[0],
                               cache_flush[0], flush_done[0], |cache_req_msg[0], |(rm0[0] | rm1[0])});
        end
        @(negedge clk);
        req_val[0] = 2'b00;
        reset = 1'b1;
        model_last[0] = 1; model_last[1] = 1;
        @(negedge clk);
        grants.delete();
        test_txn_stream(0, 2, 2, -1, -1, -1, "postrst");
        check_order("postrst", '{0, 1, 0, 1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_fixed_prio();
        test_single_read();
        test_txn_stream(0, 1, 1, 5, 1, 3, "backpressure");
        for (int i = 0; i < 4; i++) begin
            test_txn_stream(i % 2, int'($urandom_range(1, 3)), int'($urandom_range(3)), -1, -1, -1, "random");
        end
        test_flush();
        test_spurious_resp();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lab3_cache_cache_arbiter.md
Name: lab3_cache_cache_arbiter

Overview:
- Two-requester arbiter and sequencer in front of a single blocking cache; typical use is port 0 = instruction fetch, port 1 = data access.
- Accepts one request at a time from either port and forwards it on the downstream cache request interface.
- Routes the single response back to the originating port.
- Sequences cache flushes so that a flush never overlaps an in-flight transaction.

Parameters:
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with port 0 winning.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- p0_memreq_val  in  1  port 0 request valid.
- p0_memreq_rdy  out  1  port 0 request accepted.
- p0_memreq_msg  in  77  port 0 request, mem_req_4B_t.
- p0_memresp_val  out  1  port 0 response valid.
- p0_memresp_rdy  in  1  port 0 response ready.
- p0_memresp_msg  out  47  port 0 response, mem_resp_4B_t.
- p1_memreq_val / p1_memreq_rdy / p1_memreq_msg / p1_memresp_val / p1_memresp_rdy / p1_memresp_msg: same as port 0, for port 1.
- cache_req_val  out  1  downstream request valid.
- cache_req_rdy  in  1  downstream request ready.
- cache_req_msg  out  77  downstream request.
- cache_resp_val  in  1  downstream response valid.
- cache_resp_rdy  out  1  downstream response ready.
- cache_resp_msg  in  47  downstream response.
- flush  in  1  flush request; level, held high by the requester until flush_done.
- flush_done  out  1  one-cycle pulse when the flush completes.
- cache_flush  out  1  flush command to the cache.
- cache_flush_done  in  1  flush completion from the cache.

Behaviour:
- States: IDLE, SEND, WAIT, RESP, FLUSH, FDONE.
- Registers: req_buf (77b), resp_buf (47b), owner (1b), last_grant (1b).
- Reset (reset=0, async): state=IDLE, last_grant=1 so port 0 wins first; every val/rdy output, cache_flush and flush_done = 0; message outputs = 0.
- IDLE:
  - If flush=1, go to FLUSH. Flush has priority over requests; no memreq_rdy is asserted that cycle.
  - Otherwise, if any pN_memreq_val=1, pick a winner W.
    - Round-robin: the port other than last_grant if it is valid, else the valid one.
    - Fixed priority: port 0 if valid, else port 1.
  - pW_memreq_rdy=1 combinationally in the same cycle. The loser's rdy stays 0.
  - On the edge: req_buf<=pW_memreq_msg, owner<=W, last_grant<=W, go to SEND.
- SEND: cache_req_val=1, cache_req_msg=req_buf (held stable). On cache_req_rdy=1, go to WAIT.
- WAIT: cache_resp_rdy=1. On cache_resp_val=1, resp_buf<=cache_resp_msg, go to RESP.
- RESP:
  - p{owner}_memresp_val=1 with msg=resp_buf; the other port's memresp_val stays 0.
  - On p{owner}_memresp_rdy=1, go to IDLE.
- Message routing: messages pass through unmodified (opaque, type, addr, len, data untouched).
- Bubbles: one idle cycle between back-to-back transactions. Only one transaction is in flight.
- Latency:
  - Accept at cycle t; cache_req_val first high at t+1.
  - Response captured at cycle r; port response valid at r+1.
- FLUSH: cache_flush=1 until cache_flush_done=1 is sampled, then go to FDONE.
- FDONE: flush_done=1 for exactly one cycle, cache_flush=0, go to IDLE.
  - If flush is still high in IDLE the following cycle, a new flush starts; requesters must drop flush upon flush_done.
- Flush arriving during SEND, WAIT or RESP is deferred until the transaction returns to IDLE. No request is accepted before the flush starts.
- All port memreq_rdy = 0 outside IDLE.
- cache_resp_val in IDLE, SEND or FLUSH is a protocol error: it is ignored, with cache_resp_rdy=0.
- Reset asserted mid-transaction aborts immediately to the reset state. The held request/response is dropped; no completion pulse is issued.

Test Plan:
- Single read on port 0 (addr 0x1000), cache rdy immediate, response data 0xDEADBEEF one cycle later -> p0_memresp_val with data 0xDEADBEEF, opaque preserved, p1_memresp_val never high.
- Both ports valid continuously, PRIO_MODE=0, 6 requests -> grant order 0,1,0,1,0,1; each response returned to its own port.
- PRIO_MODE=1, both valid, 4 requests each -> all port 0 requests granted before any port 1 request.
- Backpressure: cache_req_rdy low 5 cycles, then p0_memresp_rdy low 3 cycles -> cache_req_msg stable throughout; exactly one response; no second request accepted meanwhile.
- flush raised while in WAIT -> cache_flush rises only after the response handshake; cache_flush_done after 10 cycles -> flush_done pulses exactly 1 cycle; no memreq_rdy asserted between flush request and flush_done.
- reset driven low during WAIT -> all outputs 0 asynchronously; after release, port 0 wins the first simultaneous request.
